msp430_ctl_seq: RTL

- Microsequencer that steps the MSP430 core through fetch, operand-fetch, execute and write-back for each instruction.
- Consumes the decoder's FORMAT, AdAs and reg_SA fields.
- Drives the instruction-register load, the PC mux (MPC), the memory-address select, the memory strobes, and the CTL_SEL hand-over to the decoder's datapath controls.
- Sits between instr_dec, the PC/register file and the memory interface.

---
 rtl/msp430_ctl_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/msp430_ctl_seq.sv
// MSP430 control microsequencer: walks each instruction through fetch, operand
// fetch, execute and write-back, and drives the datapath/memory strobes.
module msp430_ctl_seq #(
    parameter logic [3:0] PC_REG = 4'd0,
    parameter logic [3:0] CG_REG = 4'd3,
    parameter logic [3:0] SR_REG = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mem_rdy,
    input  logic [1:0] FORMAT,
    input  logic [2:0] AdAs,
    input  logic [3:0] reg_SA,
    input  logic       cond_true,
    output logic       IR_LD,
    output logic       CTL_SEL,
    output logic [2:0] MPC,
    output logic [1:0] MAB_SEL,
    output logic       MEM_RD,
    output logic       MEM_WE,
    output logic       ADDR_LD,
    output logic       SRC_LD,
    output logic       DST_LD,
    output logic       SA_INC,
    output logic       RW_EN,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        SRC_EXT = 4'd2,
        SRC_RD  = 4'd3,
        DST_EXT = 4'd4,
        DST_RD  = 4'd5,
        EXEC    = 4'd6,
        WB      = 4'd7,
        JUMP    = 4'd8
    } state_t;

    typedef struct packed {
        logic       ir_ld;
        logic       ctl_sel;
        logic [2:0] mpc;
        logic [1:0] mab_sel;
        logic       mem_rd;
        logic       mem_we;
        logic       addr_ld;
        logic       src_ld;
        logic       dst_ld;
        logic       sa_inc;
        logic       rw_en;
        logic       done;
    } ctl_t;

    localparam logic [2:0] MPC_HOLD = 3'b000;
    localparam logic [2:0] MPC_INC  = 3'b001;
    localparam logic [2:0] MPC_JMP  = 3'b010;

    state_t     state_q, state_d;
    logic       from_ext_q;
    ctl_t       ctl;

    logic [1:0] as_mode;
    logic       ad_mode;
    logic       is_cg;
    logic       is_imm;
    logic       dst_ext_needed;
    logic       mem_dst;
    state_t     after_src;

    assign as_mode        = AdAs[1:0];
    assign ad_mode        = AdAs[2];
    assign is_cg          = (reg_SA == CG_REG) || ((reg_SA == SR_REG) && as_mode[1]);
    assign is_imm         = (reg_SA == PC_REG) && (as_mode == 2'b11);
    assign dst_ext_needed = (FORMAT == 2'b00) && ad_mode;
    // Format II with a real memory source writes its result back to that address.
    assign mem_dst        = dst_ext_needed ||
                            ((FORMAT == 2'b01) && (as_mode != 2'b00) && !is_cg);
    assign after_src      = dst_ext_needed ? DST_EXT : EXEC;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        ctl     = '0;
        state_d = state_q;
        case (state_q)
            FETCH: begin
                ctl.mem_rd = run;
                if (run && mem_rdy) begin
                    ctl.ir_ld = 1'b1;
                    ctl.mpc   = MPC_INC;
                    state_d   = DECODE;
                end
            end
            DECODE: begin
                if (FORMAT == 2'b10) begin
                    state_d = JUMP;
                end else if (FORMAT == 2'b11) begin
                    ctl.done = 1'b1;
                    state_d  = FETCH;
                end else if ((as_mode == 2'b00) || is_cg) begin
                    state_d = after_src;
                end else if (as_mode == 2'b01) begin
                    state_d = SRC_EXT;
                end else begin
                    state_d = SRC_RD;
                end
            end
            SRC_EXT: begin
                ctl.mem_rd = 1'b1;
                if (mem_rdy) begin
                    ctl.mpc = MPC_INC;
                    state_d = SRC_RD;
                end
            end
            SRC_RD: begin
                ctl.mem_rd  = 1'b1;
                ctl.mab_sel = from_ext_q ? 2'd1 : (is_imm ? 2'd0 : 2'd2);
                if (mem_rdy) begin
                    ctl.src_ld  = 1'b1;
                    ctl.addr_ld = 1'b1;
                    if (as_mode == 2'b11) begin
                        if (is_imm) ctl.mpc    = MPC_INC;
                        else        ctl.sa_inc = 1'b1;
                    end
                    state_d = after_src;
                end
            end
            DST_EXT: begin
                ctl.mem_rd = 1'b1;
                if (mem_rdy) begin
                    ctl.mpc = MPC_INC;
                    state_d = DST_RD;
                end
            end
            DST_RD: begin
                ctl.mem_rd  = 1'b1;
                ctl.mab_sel = 2'd1;
                if (mem_rdy) begin
                    ctl.dst_ld  = 1'b1;
                    ctl.addr_ld = 1'b1;
                    state_d     = EXEC;
                end
            end
            EXEC: begin
                ctl.ctl_sel = 1'b1;
                if (mem_dst) begin
                    state_d = WB;
                end else begin
                    ctl.rw_en = 1'b1;
                    ctl.done  = 1'b1;
                    state_d   = FETCH;
                end
            end
            WB: begin
                ctl.ctl_sel = 1'b1;
                ctl.mab_sel = 2'd3;
                ctl.mem_we  = 1'b1;
                if (mem_rdy) begin
                    ctl.done = 1'b1;
                    state_d  = FETCH;
                end
            end
            JUMP: begin
                ctl.mpc  = cond_true ? MPC_JMP : MPC_HOLD;
                ctl.done = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
        // Reset masks the strobes immediately so a pending write cannot fire.
        if (rst) ctl = '0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q    <= FETCH;
            from_ext_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            from_ext_q <= (state_q == SRC_EXT) || ((state_q == SRC_RD) && from_ext_q);
        end
    end

    assign IR_LD      = ctl.ir_ld;
    assign CTL_SEL    = ctl.ctl_sel;
    assign MPC        = ctl.mpc;
    assign MAB_SEL    = ctl.mab_sel;
    assign MEM_RD     = ctl.mem_rd;
    assign MEM_WE     = ctl.mem_we;
    assign ADDR_LD    = ctl.addr_ld;
    assign SRC_LD     = ctl.src_ld;
    assign DST_LD     = ctl.dst_ld;
    assign SA_INC     = ctl.sa_inc;
    assign RW_EN      = ctl.rw_en;
    assign instr_done = ctl.done;
    assign state      = state_q;

endmodule
